// File: rtl/alu_shr_pkg.sv
// alu_shr_pkg
// Shared constants for the sequential 3-bit shift-right unit: default
// operand/count widths and the controller state encodings.
// No ports (package).

package alu_shr_pkg;

    localparam int ALU_SHR_WIDTH = 3;
    localparam int ALU_SHR_CNT_W = 2;

    // The unused encoding 2'd3 is treated as IDLE by the controller so a
    // corrupted state register recovers on the next clock.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage : alu_shr_pkg

// File: rtl/alu_shr_seq_if.sv
// alu_shr_seq_if
// Start/busy/done handshake bundle between the CPU control unit (master)
// and the shift-right unit (slave).
//   start : request a shift (master -> slave)
//   A     : operand (master -> slave)
//   B     : shift amount, only the low CNT_W bits matter (master -> slave)
//   R     : result, valid while done=1 and held afterwards (slave -> master)
//   busy  : shift in progress (slave -> master)
//   done  : one-cycle completion pulse (slave -> master)

interface alu_shr_seq_if
    import alu_shr_pkg::*;
#(
    parameter int WIDTH = ALU_SHR_WIDTH,
    parameter int CNT_W = ALU_SHR_CNT_W
);

    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] R;
    logic             busy;
    logic             done;

    modport master (
        output start, A, B,
        input  R, busy, done
    );

    modport slave (
        input  start, A, B,
        output R, busy, done
    );

endinterface : alu_shr_seq_if

// File: rtl/alu_shr_seq_step.sv
// alu_shr_step
// Combinational single-position right shift used by the SHIFT datapath.
//   d    : value to shift
//   fill : bit shifted in at the MSB
//   q    : {fill, d[WIDTH-1:1]}; the LSB of d is discarded

module alu_shr_step
    import alu_shr_pkg::*;
#(
    parameter int WIDTH = ALU_SHR_WIDTH
) (
    input  logic [WIDTH-1:0] d,
    input  logic             fill,
    output logic [WIDTH-1:0] q
);

    assign q = {fill, d[WIDTH-1:1]};

endmodule : alu_shr_step

// File: rtl/alu_shr_seq.sv
// alu_shr_seq
// Sequential shift-right unit for the 3-bit CPU ALU. Shifts A right by
// B[1:0] positions, one position per clock, behind a start/busy/done
// handshake. The result register R only changes on the edge entering DONE.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : alu_shr_seq_if.slave (start, A, B in; R, busy, done out)
// Build option: define ALU_SHR_ARITH_EN for an arithmetic shift (sign bit
// replicated); leave it undefined for a logical shift (zeros shifted in).

module alu_shr_seq
    import alu_shr_pkg::*;
#(
    parameter int WIDTH = ALU_SHR_WIDTH,
    parameter int CNT_W = ALU_SHR_CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    alu_shr_seq_if.slave bus
);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_sreg;
    logic [CNT_W-1:0] r_cnt;
    logic             r_fill;
    logic [WIDTH-1:0] r_r;

    logic [1:0]       w_state;
    logic             w_fill_in;
    logic [WIDTH-1:0] w_step;
    logic             w_last;

    // Fold the unused encoding back to IDLE.
    assign w_state = (r_state == ST_SHIFT || r_state == ST_DONE) ? r_state : ST_IDLE;

`ifdef ALU_SHR_ARITH_EN
    assign w_fill_in = bus.A[WIDTH-1];
`else
    assign w_fill_in = 1'b0;
`endif

    assign w_last = (r_cnt == CNT_W'(1));

    alu_shr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .d    (r_sreg),
        .fill (r_fill),
        .q    (w_step)
    );

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
            r_fill  <= 1'b0;
            r_r     <= '0;
        end else begin
            case (w_state)
                ST_SHIFT: begin
                    // start is deliberately not looked at here: requests
                    // during a shift are dropped, not queued.
                    r_sreg <= w_step;
                    r_cnt  <= r_cnt - CNT_W'(1);
                    if (w_last) begin
                        r_r     <= w_step;
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request, which gives
                    // back-to-back operation from the DONE cycle.
                    if (bus.start) begin
                        r_sreg <= bus.A;
                        r_cnt  <= bus.B[CNT_W-1:0];
                        r_fill <= w_fill_in;
                        if (bus.B[CNT_W-1:0] != '0) begin
                            r_state <= ST_SHIFT;
                        end else begin
                            r_r     <= bus.A;
                            r_state <= ST_DONE;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Pure decodes of the state register; no input reaches an output
    // without passing through a flop.
    assign bus.R    = r_r;
    assign bus.busy = (r_state == ST_SHIFT);
    assign bus.done = (r_state == ST_DONE);

endmodule : alu_shr_seq
